// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing stream sources:
// the stream-generator state type, the 8-bit LFSR feedback taps and
// a bit-reversal helper used to decorrelate a second channel.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sng_state_e;

  // Feedback taps of the maximal-length 8-bit Fibonacci LFSR: bits 7,5,4,3.
  localparam logic [7:0] LFSR8_TAPS = 8'b1011_1000;

  // Mirror an 8-bit value so bit 0 becomes bit 7 and so on.
  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR (period 255, never reaches zero
// from a non-zero seed). Load has priority over stepping.
module lfsr8
  import sc_pkg::*;
#(
  parameter logic [7:0] RESET_SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  // Next state: reload the seed, step the register, or hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (en) begin
      q_d = {q_q[6:0], ^(q_q & LFSR8_TAPS)};
    end
  end

  // State register, returns to the reset seed asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sng_pair.sv
// Dual-channel binary-to-stochastic generator. Latches two 8-bit
// probabilities and a stream length, then emits len beats of a
// (dividend, divisor) bit pair from one shared LFSR. In correlated mode
// both channels compare against the same random value; otherwise the
// divisor uses the bit-reversed value so the streams decorrelate.
module sng_pair
  import sc_pkg::*;
#(
  parameter logic [7:0] SEED  = 8'h01,
  parameter int         LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [LEN_W-1:0] len,
  input  logic             corr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dividend,
  output logic             divisor,
  output logic [7:0]       rng_out,
  output logic             done
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  sng_state_e       state_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic             corr_q;
  logic [LEN_W-1:0] cnt_q;

  logic       accept;
  logic       beat;
  logic [7:0] lfsrState;
  logic [7:0] divisorRef;

  assign accept = in_valid && (state_q == IDLE);
  assign beat   = (state_q == RUN) && out_ready;

  lfsr8 #(
    .RESET_SEED(SEED_EFF)
  ) uLfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .seed (SEED_EFF),
    .en   (beat),
    .q    (lfsrState)
  );

  // Sequencer: capture operands on accept, count beats, pulse done once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      corr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            corr_q  <= corr;
            cnt_q   <= len;
            state_q <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Random value seen by the divisor comparator, mirrored when decorrelated.
  always_comb begin
    divisorRef = corr_q ? lfsrState : bitrev8(lfsrState);
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign dividend  = (state_q == RUN) && (a_q >= lfsrState);
  assign divisor   = (state_q == RUN) && (b_q >= divisorRef);
  assign rng_out   = lfsrState;

endmodule

// File: tb/tb_sng_pair.sv
// Bench for sng_pair: a stream-level reference model predicts every output
// on every cycle, and directed plus randomized streams check bit counts,
// timing and stall behaviour against hand-computed values.
module tb_sng_pair;

   localparam logic [7:0] SEED = 8'h01;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  a = 8'h00;
   logic [7:0]  b = 8'h00;
   logic [15:0] len = 16'h0000;
   logic        corr = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        dividend;
   logic        divisor;
   logic [7:0]  rng_out;
   logic        done;

   sng_pair #(.SEED(SEED), .LEN_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .len      (len),
      .corr     (corr),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .dividend (dividend),
      .divisor  (divisor),
      .rng_out  (rng_out),
      .done     (done)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   int checks = 0;
   int fails = 0;
   int cyc = 0;

   // Edge counter used to measure latencies in cycles.
   always @(posedge clk) cyc <= cyc + 1;

   // Reference random sequence: seq[i] is the value after i steps from SEED.
   logic [7:0] seq [255];

   // Stream model: idle flag, beats still owed, beats taken, done pending.
   bit         mIdle = 1'b1;
   bit         mDone = 1'b0;
   int         mRemain = 0;
   int         mIdx = 0;
   logic [7:0] mA = 8'h00;
   logic [7:0] mB = 8'h00;
   bit         mCorr = 1'b0;
   bit         cmpEn = 1'b0;

   function automatic logic [7:0] revBits(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   function automatic logic [7:0] expRng();
      return seq[mIdx % 255];
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Model update: a transaction-level view of accept, beats and the done pulse.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mIdle   <= 1'b1;
         mDone   <= 1'b0;
         mRemain <= 0;
         mIdx    <= 0;
         mA      <= 8'h00;
         mB      <= 8'h00;
         mCorr   <= 1'b0;
      end else if (mIdle) begin
         if (in_valid) begin
            mA      <= a;
            mB      <= b;
            mCorr   <= corr;
            mIdx    <= 0;
            mIdle   <= 1'b0;
            mRemain <= int'(len);
            mDone   <= (len == 16'd0);
         end
      end else if (mRemain > 0) begin
         if (out_ready) begin
            mIdx    <= mIdx + 1;
            mRemain <= mRemain - 1;
            mDone   <= (mRemain == 1);
         end
      end else begin
         mDone <= 1'b0;
         mIdle <= 1'b1;
      end
   end

   // Cycle-by-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (cmpEn) begin
         checkOutput("in_ready", int'(in_ready), int'(mIdle));
         checkOutput("out_valid", int'(out_valid), int'(mRemain > 0));
         checkOutput("done", int'(done), int'(mDone));
         checkOutput("rng_out", int'(rng_out), int'(expRng()));
         checkOutput("dividend", int'(dividend), int'((mRemain > 0) && (mA >= expRng())));
         checkOutput("divisor", int'(divisor),
                     int'((mRemain > 0) && (mB >= (mCorr ? expRng() : revBits(expRng())))));
      end
   end

   // Per-stream statistics gathered by applyStimulus.
   int         beats, onesA, onesB, coincide, stalls, doneDiff, readyDiff, acceptCyc;
   bit         doneSeen;
   logic [1:0] bitsLog[$];
   logic [1:0] refBits[$];
   logic [7:0] rngLog[$];

   task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input int tlen,
                                input bit tcorr, input bit stall, input bit holdValid,
                                input int abortAt);
      int guard;
      beats = 0; onesA = 0; onesB = 0; coincide = 0; stalls = 0;
      doneDiff = -1; readyDiff = -1; doneSeen = 1'b0;
      bitsLog.delete();
      rngLog.delete();
      guard = 0;
      while (!in_ready && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) checkOutput("idle_timeout", 0, 1);
      in_valid  = 1'b1;
      a         = ta;
      b         = tb;
      len       = 16'(tlen);
      corr      = tcorr;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1 acceptCyc = cyc;
      for (int i = 0; i < tlen * 4 + 20; i++) begin
         @(negedge clk);
         if (!holdValid) in_valid = 1'b0;
         a         = 8'($urandom);
         b         = 8'($urandom);
         len       = 16'($urandom);
         corr      = 1'($urandom);
         out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (out_valid && out_ready) begin
            beats++;
            onesA += int'(dividend);
            onesB += int'(divisor);
            coincide += int'(dividend && divisor);
            bitsLog.push_back({dividend, divisor});
            rngLog.push_back(rng_out);
            if (beats == abortAt) begin
               @(posedge clk);
               #2 rst_n = 1'b0;
               #1;
               checkOutput("abort_out_valid", int'(out_valid), 0);
               checkOutput("abort_in_ready", int'(in_ready), 1);
               checkOutput("abort_rng", int'(rng_out), int'(SEED));
               checkOutput("abort_done", int'(done), 0);
               in_valid  = 1'b0;
               out_ready = 1'b1;
               @(negedge clk);
               @(negedge clk);
               rst_n = 1'b1;
               return;
            end
         end else if (out_valid) begin
            stalls++;
         end
         if (done) begin
            doneSeen = 1'b1;
            doneDiff = cyc - acceptCyc;
            checkOutput("ready_low_in_done", int'(in_ready), 0);
            in_valid = 1'b0;
            break;
         end
      end
      if (!doneSeen) begin
         checkOutput("done_timeout", 0, 1);
         in_valid = 1'b0;
      end else begin
         @(negedge clk);
         #1;
         readyDiff = cyc - acceptCyc;
         checkOutput("ready_after_done", int'(in_ready), 1);
         checkOutput("done_one_cycle", int'(done), 0);
      end
   endtask

   initial begin
      logic [7:0] s;
      logic [255:0] seen;
      int distinct;
      logic [7:0] expFirst [5];

      // Build and pin the reference sequence from the feedback polynomial.
      s = SEED;
      seen = '0;
      for (int i = 0; i < 255; i++) begin
         seq[i] = s;
         seen[s] = 1'b1;
         s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      end
      distinct = 0;
      for (int i = 0; i < 256; i++) distinct += int'(seen[i]);
      checkOutput("model_period", int'(s), int'(SEED));
      checkOutput("model_distinct", distinct, 255);
      checkOutput("model_zero_absent", int'(seen[0]), 0);
      checkOutput("model_seq4", int'(seq[4]), 8'h11);

      // Reset and check the idle outputs.
      #2 rst_n = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("rst_in_ready", int'(in_ready), 1);
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_dividend", int'(dividend), 0);
      checkOutput("rst_divisor", int'(divisor), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_rng", int'(rng_out), int'(SEED));
      cmpEn = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] full period, a=128 b=255 correlated");
      applyStimulus(8'd128, 8'd255, 255, 1'b1, 1'b0, 1'b0, 0);
      checkOutput("p1_beats", beats, 255);
      checkOutput("p1_onesA", onesA, 128);
      checkOutput("p1_onesB", onesB, 255);
      checkOutput("p1_done_lat", doneDiff, 255);
      checkOutput("p1_ready_lat", readyDiff, 256);

      $display("[TB] a=100 b=200 correlated and decorrelated");
      applyStimulus(8'd100, 8'd200, 255, 1'b1, 1'b0, 1'b0, 0);
      checkOutput("p2c_onesA", onesA, 100);
      checkOutput("p2c_onesB", onesB, 200);
      checkOutput("p2c_coincide", coincide, 100);
      applyStimulus(8'd100, 8'd200, 255, 1'b0, 1'b0, 1'b0, 0);
      checkOutput("p2d_onesA", onesA, 100);
      checkOutput("p2d_onesB", onesB, 200);
      checkOutput("p2d_coincide_below_100", int'(coincide < 100), 1);

      $display("[TB] a=0 b=255 len=10");
      applyStimulus(8'd0, 8'd255, 10, 1'b1, 1'b0, 1'b0, 0);
      checkOutput("p3_beats", beats, 10);
      checkOutput("p3_onesA", onesA, 0);
      checkOutput("p3_onesB", onesB, 10);
      expFirst = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
      for (int i = 0; i < 5; i++) checkOutput("p3_rng_seq", int'(rngLog[i]), int'(expFirst[i]));

      $display("[TB] len=20 unstalled versus randomly stalled");
      begin
         logic [7:0] ra, rb;
         bit rc;
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         applyStimulus(ra, rb, 20, rc, 1'b0, 1'b0, 0);
         refBits = bitsLog;
         applyStimulus(ra, rb, 20, rc, 1'b1, 1'b0, 0);
         checkOutput("p4_beats", beats, 20);
         checkOutput("p4_done_lat", doneDiff, 20 + stalls);
         for (int i = 0; i < 20; i++) checkOutput("p4_same_bits", int'(bitsLog[i]), int'(refBits[i]));
      end

      $display("[TB] len=0 and in_valid held during RUN");
      applyStimulus(8'd77, 8'd33, 0, 1'b1, 1'b0, 1'b0, 0);
      checkOutput("p5_beats", beats, 0);
      checkOutput("p5_done_lat", doneDiff, 0);
      checkOutput("p5_ready_lat", readyDiff, 1);
      applyStimulus(8'd60, 8'd90, 12, 1'b1, 1'b0, 1'b1, 0);
      checkOutput("p5h_beats", beats, 12);
      checkOutput("p5h_done_lat", doneDiff, 12);

      $display("[TB] reset mid-stream, then restart");
      applyStimulus(8'd150, 8'd220, 50, 1'b0, 1'b0, 1'b0, 7);
      checkOutput("p6_abort_beats", beats, 7);
      applyStimulus(8'd150, 8'd220, 50, 1'b0, 1'b0, 1'b0, 0);
      checkOutput("p6_beats", beats, 50);
      checkOutput("p6_first_rng", int'(rngLog[0]), int'(SEED));
      checkOutput("p6_done_lat", doneDiff, 50);

      $display("[TB] randomized streams");
      for (int t = 0; t < 8; t++) begin
         int rl;
         rl = int'($urandom_range(0, 40));
         applyStimulus(8'($urandom), 8'($urandom), rl, 1'($urandom), 1'($urandom), 1'b0, 0);
         checkOutput("rand_beats", beats, rl);
         checkOutput("rand_done_lat", doneDiff, rl + stalls);
      end

      @(negedge clk);
      cmpEn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
